snoop_req_queue: RTL and testbench
==================================

// Module: snoop_req_queue
// PURPOSE
//  Upstream ingress stage for the L1D snoop engine. Accepts coherence snoop
//  requests from the interconnect and buffers them in a small in-order FIFO.
//  Issues them one at a time to the snoop unit as {line_addr, type} with a
//  single-cycle handshake pulse. A request is issued only when the snoop unit
//  reports idle (sn_empty), and never while an earlier issue is still settling.
// PARAMETERS
//  DEPTH       4   FIFO entries; power of two, >= 2
//  PADDR_W     20  physical address width
//  OFFSET_W    6   line offset bits (64 B line)
//  TYPE_W      4   snoop type width
// PORTS
//  clk            in   1          clock
//  rstn           in   1          asynchronous, active-high reset (1 = reset)
//  snp_valid_i    in   1          interconnect snoop request valid
//  snp_ready_o    out  1          queue can accept (= !full)
//  snp_addr_i     in   PADDR_W    snoop physical address (offset bits ignored)
//  snp_type_i     in   TYPE_W     snoop type: 8, 9 or 11 legal
//  sn_req_o       out  18         {paddr[19:6], type}; feeds snoop sn_req
//  sn_req_hsk_o   out  1          1-cycle issue pulse; sn_req_o valid this cycle
//  sn_empty_i     in   1          snoop unit idle (registered inside snoop unit)
//  q_count_o      out  $clog2(DEPTH)+1  current occupancy
//  busy_o         out  1          FSM not in S_IDLE
//  err_illegal_o  out  1          1-cycle pulse: illegal type dropped at push
// BEHAVIOUR
//  Reset (async, rstn=1): FIFO empty, rd/wr ptr=0, count=0, FSM=S_IDLE.
//   Outputs: sn_req_hsk_o=0, sn_req_o=0, err_illegal_o=0, busy_o=0,
//   snp_ready_o=1 after release. Reset mid-operation discards all entries and
//   any in-flight issue tracking.
//  Push: snp_valid_i & snp_ready_o. Legal type -> write {addr[19:6],type} at
//   wr_ptr; wr_ptr wraps modulo DEPTH. Illegal type -> nothing is written;
//   err_illegal_o pulses the next cycle.
//  snp_ready_o = (count != DEPTH). No push is accepted when full, even if a pop
//   occurs in the same cycle.
//  FSM states:
//   S_IDLE: if count!=0 & sn_empty_i -> pop head, sn_req_hsk_o=1, S_WAIT_BUSY.
//   S_WAIT_BUSY: one cycle (sn_empty_i is still stale high) -> S_WAIT_DONE.
//   S_WAIT_DONE: sn_empty_i==1 -> S_IDLE. The next issue is at the earliest one
//    cycle later.
//  sn_req_o is combinational from the FIFO head and is qualified only by
//   sn_req_hsk_o. The head entry is held stable while it waits.
//  Issue latency (bypass off): a push at cycle N into an empty queue with an
//   idle snoop unit produces hsk at N+1. Back-to-back issues are >= 3 cycles
//   apart.
//  Simultaneous push and pop (not full): count unchanged; both pointers advance.
//  Ordering is strict FIFO; no address merging or reordering.
//  Pointer wrap: DEPTH pushes followed by DEPTH pops return both ptrs to 0.
// CONFIGURATION
//  SNOOP_REQ_Q_BYPASS_EN defined: in S_IDLE with count==0 & sn_empty_i, a legal
//   push is issued in the same cycle (hsk at N). The entry is not written, and
//   the FSM goes to S_WAIT_BUSY. Illegal types are never bypassed.
//  SNOOP_REQ_Q_BYPASS_EN undefined: every request passes through the FIFO
//   (minimum 1-cycle latency).
// TESTING
//  1 Push addr=0x12340, type=8, queue empty, sn_empty_i=1 -> hsk next cycle,
//    sn_req_o=0x048D8 (0x48D<<4|8); busy_o=1 until sn_empty_i returns to 1.
//  2 Push 5 legal requests back-to-back with sn_empty_i=0 -> 4 accepted,
//    snp_ready_o=0 on the 5th, q_count_o=4; release sn_empty_i -> 4 issues
//    in push order, each >= 3 cycles apart.
//  3 Push type=5 -> no entry written, q_count_o unchanged, err_illegal_o=1 for
//    exactly 1 cycle, no hsk.
//  4 Full queue, pop and push in the same cycle -> push refused, q_count_o=3.
//    Run 8 push/pop pairs -> pointers wrap and data order is preserved.
//  5 Assert rstn during S_WAIT_DONE with 2 entries queued -> q_count_o=0, busy_o=0,
//    no hsk after release until a new push arrives.
//  6 (BYPASS_EN) Push addr=0x00040, type=11 into an idle empty queue -> hsk in
//    the same cycle, sn_req_o=0x0001B, q_count_o stays 0.

Source files
------------

// File: rtl/snoop_req_queue_if.sv
// Snoop request ingress/issue bundle: interconnect push side plus snoop-unit issue side.
// The slave modport is the queue; the master modport is the surrounding fabric/bench.
interface snoop_req_queue_if #(
  parameter int unsigned PADDR_W = 20,
  parameter int unsigned TYPE_W  = 4,
  parameter int unsigned REQ_W   = 18
);
  logic               snp_valid_i;
  logic               snp_ready_o;
  logic [PADDR_W-1:0] snp_addr_i;
  logic [TYPE_W-1:0]  snp_type_i;
  logic [REQ_W-1:0]   sn_req_o;
  logic               sn_req_hsk_o;
  logic               sn_empty_i;

  modport slave (
    input  snp_valid_i, snp_addr_i, snp_type_i, sn_empty_i,
    output snp_ready_o, sn_req_o, sn_req_hsk_o
  );

  modport master (
    output snp_valid_i, snp_addr_i, snp_type_i, sn_empty_i,
    input  snp_ready_o, sn_req_o, sn_req_hsk_o
  );
endinterface

// File: rtl/snoop_req_queue.sv
// In-order snoop request FIFO feeding the L1D snoop unit one request at a time.
// Optional same-cycle issue into an idle empty queue: define SNOOP_REQ_Q_BYPASS_EN.
module snoop_req_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PADDR_W  = 20,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned TYPE_W   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  snoop_req_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   q_count_o,
  output logic                     busy_o,
  output logic                     err_illegal_o
);

  localparam int unsigned LINE_W = PADDR_W - OFFSET_W;
  localparam int unsigned REQ_W  = LINE_W + TYPE_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [TYPE_W-1:0] TYPE_A = TYPE_W'(8);
  localparam logic [TYPE_W-1:0] TYPE_B = TYPE_W'(9);
  localparam logic [TYPE_W-1:0] TYPE_C = TYPE_W'(11);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [REQ_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q;
  logic               busy_q;
  logic               ready_q;

  logic               type_legal_c;
  logic               push_req_c;
  logic               push_legal_c;
  logic               write_c;
  logic               pop_c;
  logic               hsk_c;
  logic               byp_c;
  logic [REQ_W-1:0]   payload_c;
  logic               unused_offset_c;

  // Line offset bits never reach the snoop unit.
  assign unused_offset_c = ^bus.snp_addr_i[OFFSET_W-1:0];

  assign type_legal_c = (bus.snp_type_i == TYPE_A) ||
                        (bus.snp_type_i == TYPE_B) ||
                        (bus.snp_type_i == TYPE_C);
  assign push_req_c   = bus.snp_valid_i & ready_q;
  assign push_legal_c = push_req_c & type_legal_c;
  assign payload_c    = {bus.snp_addr_i[PADDR_W-1:OFFSET_W], bus.snp_type_i};
  assign write_c      = push_legal_c & ~byp_c;

  // Issue FSM: one request in flight, wait out the stale sn_empty cycle.
  always_comb begin
    state_d = state_q;
    hsk_c   = 1'b0;
    pop_c   = 1'b0;
    byp_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != CNT_W'(0)) && bus.sn_empty_i) begin
          hsk_c   = 1'b1;
          pop_c   = 1'b1;
          state_d = S_WAIT_BUSY;
        end
`ifdef SNOOP_REQ_Q_BYPASS_EN
        else if (push_legal_c && bus.sn_empty_i) begin
          byp_c   = 1'b1;
          hsk_c   = 1'b1;
          state_d = S_WAIT_BUSY;
        end
`endif
      end
      S_WAIT_BUSY: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.sn_empty_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (write_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (write_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!write_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= push_req_c & ~type_legal_c;
      busy_q   <= (state_d != S_IDLE);
      ready_q  <= (count_d != CNT_W'(DEPTH));
    end
  end

  // Storage is cleared on reset so the head reads zero after reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_c) begin
      mem_q[wr_ptr_q] <= payload_c;
    end
  end

  assign bus.snp_ready_o  = ready_q;
  assign bus.sn_req_hsk_o = hsk_c;
  assign bus.sn_req_o     = byp_c ? payload_c : mem_q[rd_ptr_q];
  assign q_count_o        = count_q;
  assign busy_o           = busy_q;
  assign err_illegal_o    = err_q;

endmodule

// File: tb/tb_snoop_req_queue.sv
// Bench for snoop_req_queue: push vectors table, scoreboard of issued requests,
// and hand-written sequences for full/pop overlap, wrap, reset and bypass.
module tb_snoop_req_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PADDR_W  = 20;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned TYPE_W   = 4;
  localparam int unsigned REQ_W    = 18;
  localparam int unsigned CNT_W    = 3;
`ifdef SNOOP_REQ_Q_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef logic [REQ_W-1:0] req_t;

  typedef struct {
    logic [PADDR_W-1:0] addr;
    logic [TYPE_W-1:0]  typ;
    logic               exp_ready;
    logic               exp_err;
    int                 exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic [CNT_W-1:0] q_count;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  snoop_req_queue_if #(.PADDR_W(PADDR_W), .TYPE_W(TYPE_W), .REQ_W(REQ_W)) bus ();

  snoop_req_queue #(.DEPTH(DEPTH), .PADDR_W(PADDR_W), .OFFSET_W(OFFSET_W), .TYPE_W(TYPE_W)) dut (
    .clk           (clk),
    .rstn          (rst),
    .bus           (bus),
    .q_count_o     (q_count),
    .busy_o        (busy),
    .err_illegal_o (err)
  );

  // Snoop unit responder: goes busy the cycle after an issue, idle again 2 cycles later.
  int   cyc = 0;
  int   sbusy = 0;
  logic hsk_n = 1'b0;
  req_t log_req [64];
  int   log_cyc [64];
  int   widx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) sbusy <= 0;
    else if (hsk_n) sbusy <= 2;
    else if (sbusy != 0) sbusy <= sbusy - 1;
  end

  assign bus.sn_empty_i = !hold && (sbusy == 0);

  always @(negedge clk) begin
    hsk_n <= bus.sn_req_hsk_o;
    if (bus.sn_req_hsk_o && !rst && widx < 64) begin
      log_req[widx] <= bus.sn_req_o;
      log_cyc[widx] <= cyc;
      widx          <= widx + 1;
    end
  end

  int   checks = 0;
  int   errors = 0;
  req_t sb [$];
  int   ridx = 0;
  int   last_cyc = 0;
  bit   last_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PADDR_W-1:0] a, input logic [TYPE_W-1:0] t);
    bus.snp_valid_i = v;
    bus.snp_addr_i  = a;
    bus.snp_type_i  = t;
  endtask

  function automatic req_t mk(input logic [PADDR_W-1:0] a, input logic [TYPE_W-1:0] t);
    return {a[PADDR_W-1:OFFSET_W], t};
  endfunction

  // Match logged issues against the scoreboard; also checks issue spacing.
  task automatic process_log();
    req_t e;
    while (ridx < widx) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hsk actual_req=0x%0h required=no_issue (cycle %0d)",
                 log_req[ridx], log_cyc[ridx]);
      end else begin
        e = sb.pop_front();
        chk("issue_order", 32'(log_req[ridx]), 32'(e));
        if (last_vld) chk("issue_spacing", 32'(log_cyc[ridx] - last_cyc >= 3), 32'd1);
      end
      last_cyc = log_cyc[ridx];
      last_vld = 1'b1;
      ridx++;
    end
  endtask

  task automatic drain(input int budget);
    for (int b = 0; b < budget; b++) begin
      @(negedge clk);
      process_log();
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   n;
    int   h;
    int   c;
    int   w0;

    vecs[0] = '{20'h12340, 4'd8,  1'b1, 1'b0, 1};
    vecs[1] = '{20'h00080, 4'd5,  1'b1, 1'b1, 1};
    vecs[2] = '{20'hFFFC0, 4'd9,  1'b1, 1'b0, 2};
    vecs[3] = '{20'h00001, 4'd11, 1'b1, 1'b0, 3};
    vecs[4] = '{20'h0AB40, 4'd0,  1'b1, 1'b1, 3};
    vecs[5] = '{20'h55540, 4'd11, 1'b1, 1'b0, 4};
    vecs[6] = '{20'h77740, 4'd8,  1'b0, 1'b0, 4};

    rst  = 1'b1;
    hold = 1'b0;
    drive(1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_hsk",   32'(bus.sn_req_hsk_o), 32'd0);
    chk("rst_req",   32'(bus.sn_req_o), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(bus.snp_ready_o), 32'd1);

    // Single request into an idle empty queue.
    step();
    drive(1'b1, 20'h12340, 4'd8);
    sb.push_back(req_t'(18'h048D8));
    n = cyc;
    h = n + LAT;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      c = cyc;
      if (c == h) begin
        chk("t1_hsk", 32'(bus.sn_req_hsk_o), 32'd1);
        chk("t1_req", 32'(bus.sn_req_o), 32'h048D8);
      end
      if (c == h + 1) chk("t1_busy_h1", 32'(busy), 32'd1);
      if (c == h + 3) chk("t1_busy_h3", 32'(busy), 32'd1);
      if (c == h + 4) chk("t1_busy_h4", 32'(busy), 32'd0);
      step();
      bus.snp_valid_i = 1'b0;
    end
    drain(20);
    chk("t1_latency", 32'(last_cyc - n), 32'(LAT));

    // Push vector table with the snoop unit held busy.
    repeat (4) step();
    hold = 1'b1;
    repeat (4) step();
    foreach (vecs[i]) begin
      step();
      drive(1'b1, vecs[i].addr, vecs[i].typ);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.snp_ready_o), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_ready && (vecs[i].typ == 4'd8 || vecs[i].typ == 4'd9 || vecs[i].typ == 4'd11))
        sb.push_back(mk(vecs[i].addr, vecs[i].typ));
      step();
      bus.snp_valid_i = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_count", i), 32'(q_count), 32'(vecs[i].exp_count));
      step();
      @(negedge clk);
      chk($sformatf("v%0d_err_clr", i), 32'(err), 32'd0);
    end
    process_log();
    step();
    hold = 1'b0;
    drain(60);
    repeat (2) @(negedge clk);
    chk("tbl_drained_count", 32'(q_count), 32'd0);

    // Push and pop in the same cycle, not full then full.
    repeat (6) step();
    hold = 1'b1;
    step(); drive(1'b1, 20'h01040, 4'd8);  sb.push_back(mk(20'h01040, 4'd8));
    step(); drive(1'b1, 20'h02080, 4'd9);  sb.push_back(mk(20'h02080, 4'd9));
    step(); bus.snp_valid_i = 1'b0;
    step();
    hold = 1'b0;
    drive(1'b1, 20'h030C0, 4'd11);
    @(negedge clk);
    chk("ovl_hsk",   32'(bus.sn_req_hsk_o), 32'd1);
    chk("ovl_ready", 32'(bus.snp_ready_o), 32'd1);
    sb.push_back(mk(20'h030C0, 4'd11));
    step();
    bus.snp_valid_i = 1'b0;
    hold = 1'b1;
    @(negedge clk);
    chk("ovl_count", 32'(q_count), 32'd2);
    step(); drive(1'b1, 20'h04100, 4'd8);  sb.push_back(mk(20'h04100, 4'd8));
    step(); drive(1'b1, 20'h05140, 4'd9);  sb.push_back(mk(20'h05140, 4'd9));
    step(); bus.snp_valid_i = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(q_count), 32'd4);
    chk("full_ready", 32'(bus.snp_ready_o), 32'd0);
    step();
    hold = 1'b0;
    step();
    drive(1'b1, 20'h06180, 4'd11);
    @(negedge clk);
    chk("full_pop_hsk",   32'(bus.sn_req_hsk_o), 32'd1);
    chk("full_pop_ready", 32'(bus.snp_ready_o), 32'd0);
    step();
    bus.snp_valid_i = 1'b0;
    @(negedge clk);
    chk("full_pop_count", 32'(q_count), 32'd3);
    drain(60);

    // Eight push/pop pairs walk the pointers around the ring.
    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, PADDR_W'(32'h10000 + i * 32'h1040), (i % 2 == 0) ? 4'd9 : 4'd11);
      sb.push_back(mk(PADDR_W'(32'h10000 + i * 32'h1040), (i % 2 == 0) ? 4'd9 : 4'd11));
      step();
      bus.snp_valid_i = 1'b0;
      drain(30);
    end
    repeat (4) @(negedge clk);
    chk("wrap_count", 32'(q_count), 32'd0);

    // Reset during S_WAIT_DONE with two entries still queued.
    repeat (6) step();
    hold = 1'b1;
    step(); drive(1'b1, 20'h20040, 4'd8);  sb.push_back(mk(20'h20040, 4'd8));
    step(); drive(1'b1, 20'h21080, 4'd9);
    step(); drive(1'b1, 20'h220C0, 4'd11);
    step(); bus.snp_valid_i = 1'b0;
    step();
    hold = 1'b0;
    @(negedge clk);
    chk("rstmid_hsk", 32'(bus.sn_req_hsk_o), 32'd1);
    step();
    hold = 1'b1;
    step();
    @(negedge clk);
    chk("rstmid_busy",  32'(busy), 32'd1);
    chk("rstmid_count", 32'(q_count), 32'd2);
    process_log();
    step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    hold = 1'b0;
    sb.delete();
    last_vld = 1'b0;
    @(negedge clk);
    chk("rstmid_post_count", 32'(q_count), 32'd0);
    chk("rstmid_post_busy",  32'(busy), 32'd0);
    chk("rstmid_post_ready", 32'(bus.snp_ready_o), 32'd1);
    ridx = widx;
    w0   = widx;
    repeat (10) @(negedge clk);
    chk("rstmid_no_hsk", 32'(widx - w0), 32'd0);
    process_log();
    step();
    drive(1'b1, 20'h23100, 4'd9);
    sb.push_back(mk(20'h23100, 4'd9));
    step();
    bus.snp_valid_i = 1'b0;
    drain(30);

    // Same-cycle issue into an idle empty queue (bypass) or one-cycle latency.
    repeat (6) step();
    step();
    drive(1'b1, 20'h00040, 4'd11);
    sb.push_back(req_t'(18'h0001B));
    @(negedge clk);
`ifdef SNOOP_REQ_Q_BYPASS_EN
    chk("byp_hsk", 32'(bus.sn_req_hsk_o), 32'd1);
    chk("byp_req", 32'(bus.sn_req_o), 32'h0001B);
    chk("byp_count", 32'(q_count), 32'd0);
    step();
    bus.snp_valid_i = 1'b0;
    @(negedge clk);
    chk("byp_count_next", 32'(q_count), 32'd0);
`else
    chk("nobyp_hsk", 32'(bus.sn_req_hsk_o), 32'd0);
    step();
    bus.snp_valid_i = 1'b0;
    @(negedge clk);
    chk("nobyp_count_next", 32'(q_count), 32'd1);
    chk("nobyp_hsk_next",   32'(bus.sn_req_hsk_o), 32'd1);
    chk("nobyp_req_next",   32'(bus.sn_req_o), 32'h0001B);
`endif
    drain(30);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
